// File: rtl/alu_serial_pkg.sv
// Shared constants and slice-control decode for the bit-serial ALU sequencer.
// Build option: ALU_SERIAL_SLT_EN enables opcode 100 (set-less-than).
package alu_serial_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [1:0] SOP_AND  = 2'b00;
  localparam logic [1:0] SOP_OR   = 2'b01;
  localparam logic [1:0] SOP_ADD  = 2'b10;
  localparam logic [1:0] SOP_LESS = 2'b11;

  typedef struct packed {
    logic       ainvert;
    logic       binvert;
    logic [1:0] op;
  } slice_ctrl_t;

  // Opcodes that drive the slice; everything else runs with inputs forced to 0.
  function automatic logic op_valid(input logic [2:0] opc);
    case (opc)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: op_valid = 1'b1;
`ifdef ALU_SERIAL_SLT_EN
      OP_SLT:                                op_valid = 1'b1;
`endif
      default:                               op_valid = 1'b0;
    endcase
  endfunction

  function automatic slice_ctrl_t slice_ctrl(input logic [2:0] opc);
    slice_ctrl = '{ainvert: 1'b0, binvert: 1'b0, op: SOP_AND};
    case (opc)
      OP_OR:  slice_ctrl.op = SOP_OR;
      OP_ADD: slice_ctrl.op = SOP_ADD;
      OP_SUB: slice_ctrl = '{ainvert: 1'b0, binvert: 1'b1, op: SOP_ADD};
`ifdef ALU_SERIAL_SLT_EN
      OP_SLT: slice_ctrl = '{ainvert: 1'b0, binvert: 1'b1, op: SOP_ADD};
`endif
      OP_NOR: slice_ctrl = '{ainvert: 1'b1, binvert: 1'b1, op: SOP_AND};
      default: ;
    endcase
  endfunction

endpackage

// File: rtl/alu_slice_c.sv
// 1-bit ALU slice (AND/OR/ADD/LESS with operand inversion) exposing its carry-out.
module alu_slice_c
  import alu_serial_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cy_in,
  input  logic       less,
  input  logic       ainvert,
  input  logic       binvert,
  input  logic [1:0] op,
  output logic       result,
  output logic       cy_out
);

  logic aa;
  logic bb;

  always_comb begin
    aa     = a ^ ainvert;
    bb     = b ^ binvert;
    cy_out = (aa & bb) | (aa & cy_in) | (bb & cy_in);
    case (op)
      SOP_AND: result = aa & bb;
      SOP_OR:  result = aa | bb;
      SOP_ADD: result = aa ^ bb ^ cy_in;
      default: result = less;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: runs one alu_slice_c LSB-first over WIDTH cycles.
// Build option: ALU_SERIAL_SLT_EN enables opcode 100 (set-less-than).
module alu_serial_ctrl
  import alu_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [2:0]         op_q, op_d;
  logic               carry_q, carry_d;
  logic               ready_d, busy_d, done_d, zero_d, ovf_d;
  logic [WIDTH-1:0]   result_d;

  slice_ctrl_t        ctrl;
  logic               op_ok;
  logic               s_res, s_cout;
  logic [WIDTH-1:0]   word_c;
  logic               v_c;

  // Reserved opcodes keep the slice inputs at 0 so the result stays 0.
  assign ctrl  = slice_ctrl(op_q);
  assign op_ok = op_valid(op_q);

  alu_slice_c u_slice (
    .a       (op_ok & a_q[0]),
    .b       (op_ok & b_q[0]),
    .cy_in   (carry_q),
    .less    (1'b0),
    .ainvert (ctrl.ainvert),
    .binvert (ctrl.binvert),
    .op      (ctrl.op),
    .result  (s_res),
    .cy_out  (s_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      zero    <= 1'b1;
      ovf     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      ready   <= ready_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      zero    <= zero_d;
      ovf     <= ovf_d;
    end
  end

  // Next state, datapath shift and result assembly on the final bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    op_d     = op_q;
    carry_d  = carry_q;
    result_d = result;
    zero_d   = zero;
    ovf_d    = ovf;
    word_c   = {s_res, acc_q[WIDTH-1:1]};
    v_c      = carry_q ^ s_cout;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          op_d    = opcode;
          cnt_d   = '0;
          carry_d = (opcode == OP_SUB) || (opcode == OP_SLT);
        end
      end
      S_RUN: begin
        cnt_d   = cnt_q + CW'(1);
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = word_c;
        carry_d = s_cout;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          case (op_q)
            OP_ADD, OP_SUB: begin
              result_d = word_c;
              ovf_d    = v_c;
            end
            OP_AND, OP_OR, OP_NOR: begin
              result_d = word_c;
              ovf_d    = 1'b0;
            end
`ifdef ALU_SERIAL_SLT_EN
            OP_SLT: begin
              result_d = WIDTH'(s_res ^ v_c);
              ovf_d    = 1'b0;
            end
`endif
            default: begin
              result_d = '0;
              ovf_d    = 1'b0;
            end
          endcase
          zero_d = (result_d == '0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_RUN);
    done_d  = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Self-checking bench for alu_serial_ctrl (WIDTH=8) against an arithmetic reference model.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   opcode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;

  int checks;
  int failures;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .zero   (zero),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {result, zero, ovf} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         v;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: begin
        r = x + y;
        v = ($signed(x) + $signed(y) > 127) || ($signed(x) + $signed(y) < -128);
      end
      3'd3: begin
        r = x - y;
        v = ($signed(x) - $signed(y) > 127) || ($signed(x) - $signed(y) < -128);
      end
`ifdef ALU_SERIAL_SLT_EN
      3'd4: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
`endif
      3'd5: r = ~(x | y);
      default: r = '0;
    endcase
    model = {r, (r == '0), v};
  endfunction

  // Issues one operation from a negedge; returns cycles from accepting edge to done (0 = timeout).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit hold, output int lat, output int busy_bad);
    int n;
    n = 0;
    lat = 0;
    busy_bad = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    opcode = op;
    a      = av;
    b      = bv;
    start  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (hold) begin
        a      = W'($urandom);
        b      = W'($urandom);
        opcode = 3'($urandom);
      end else begin
        start = 1'b0;
      end
      if (i <= int'(W) && busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [2:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int lat, input int busy_bad);
    logic [W+1:0] exp;
    exp = model(op, av, bv);
    checks++;
    if ({result, zero, ovf} !== exp) begin
      failures++;
      $display("FAIL %s op=%0d a=%h b=%h got res=%h z=%b v=%b want res=%h z=%b v=%b",
               name, op, av, bv, result, zero, ovf, exp[W+1:2], exp[1], exp[0]);
    end
    checks++;
    if (lat != int'(W) + 1 || busy_bad != 0) begin
      failures++;
      $display("FAIL %s_timing latency=%0d busy_gaps=%0d want latency=%0d busy_gaps=0",
               name, lat, busy_bad, W + 1);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = '0;
    a      = '0;
    b      = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready, busy, done, result, zero, ovf} !== {1'b1, 1'b0, 1'b0, W'(0), 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset rdy=%b busy=%b done=%b res=%h z=%b v=%b want 1 0 0 00 1 0",
               ready, busy, done, result, zero, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]   ops [9] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd5, 3'd0, 3'd1, 3'd6, 3'd7};
    logic [W-1:0] as  [9] = '{8'h7F, 8'h05, 8'h80, 8'h01, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'h55};
    logic [W-1:0] bs  [9] = '{8'h01, 8'h05, 8'h01, 8'h80, 8'h0F, 8'h3C, 8'h0F, 8'h55, 8'hAA};
    int lat, bb;
    for (int i = 0; i < 9; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, lat, bb);
      check_op("directed", ops[i], as[i], bs[i], lat, bb);
    end
  endtask

  task automatic test_random();
    logic [2:0]   op;
    logic [W-1:0] av, bv;
    int lat, bb;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      av = W'($urandom);
      bv = W'($urandom);
      if (i % 10 == 0) av = 8'h80;
      if (i % 10 == 1) bv = 8'h7F;
      run_op(op, av, bv, 1'b0, lat, bb);
      check_op("random", op, av, bv, lat, bb);
    end
  endtask

  task automatic test_start_held();
    int lat, bb, extra;
    run_op(3'd2, 8'h3C, 8'h21, 1'b1, lat, bb);
    check_op("start_held", 3'd2, 8'h3C, 8'h21, lat, bb);
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || ready !== 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL start_held_queued extra_activity_cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    run_op(3'd3, 8'h10, 8'h20, 1'b0, lat, bb);
    check_op("b2b_first", 3'd3, 8'h10, 8'h20, lat, bb);
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ready got=%b want=1", ready);
    end
    run_op(3'd0, 8'hC3, 8'h5A, 1'b0, lat, bb);
    check_op("b2b_second", 3'd0, 8'hC3, 8'h5A, lat, bb);
  endtask

  task automatic test_reset_mid_run();
    int lat, bb, spurious;
    run_op(3'd1, 8'h12, 8'h40, 1'b0, lat, bb);
    check_op("pre_reset", 3'd1, 8'h12, 8'h40, lat, bb);
    @(negedge clk);
    opcode = 3'd2;
    a      = 8'h11;
    b      = 8'h22;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done, result, zero, ovf} !== {1'b1, 1'b0, 1'b0, W'(0), 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_run rdy=%b busy=%b done=%b res=%h z=%b v=%b want 1 0 0 00 1 0",
               ready, busy, done, result, zero, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      failures++;
      $display("FAIL reset_mid_run_done spurious_cycles=%0d want 0", spurious);
    end
    run_op(3'd2, 8'h64, 8'h64, 1'b0, lat, bb);
    check_op("post_reset", 3'd2, 8'h64, 8'h64, lat, bb);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
